// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the CPU step/run controller.
//   state_e : controller state encoding (STEP, RUN, HALT)
//   DIV_W   : width of the RUN-mode clock divider (covers RUN_DIV up to 65535)
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STEP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int DIV_W = 16;

endpackage

// File: rtl/btn_edge_sync.sv
// Button synchronizer and rising-edge detector.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   btn        : debounced button level, asynchronous to clk
//   edge_pulse : one-cycle pulse per rising edge of the synchronized level
// The detector only arms once the synchronizer has been refilled after reset
// and has shown a genuine low, so a button held through reset gives no pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic edge_pulse
);

  logic       meta_r;
  logic       sync_r;
  logic       prev_r;
  logic       armed_r;
  logic [1:0] fill_r;

  // Two-flop synchronizer, previous-level register and arming logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r  <= 1'b0;
      sync_r  <= 1'b0;
      prev_r  <= 1'b0;
      armed_r <= 1'b0;
      fill_r  <= 2'd0;
    end else begin
      meta_r <= btn;
      sync_r <= meta_r;
      prev_r <= sync_r;
      // fill_r reaches 2 once sync_r carries a real sample, not a reset value
      if (fill_r != 2'd2) begin
        fill_r <= fill_r + 2'd1;
      end else begin
        fill_r <= fill_r;
      end
      if ((fill_r == 2'd2) && !sync_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign edge_pulse = sync_r & ~prev_r & armed_r;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU single-step / free-run clock-enable controller.
// Ports:
//   clk       : system clock (rising edge)
//   rst       : asynchronous active-high reset
//   btn_step  : step button level (asynchronous)
//   btn_mode  : RUN/STEP toggle button level (asynchronous)
//   cpu_halt  : halt request, synchronous to clk
//   cpu_en    : registered processor clock-enable
//   run_mode  : high while in RUN
//   halted    : high while in HALT
//   step_cnt  : saturating count of cpu_en pulses
// Parameters: RUN_DIV (clk cycles per cpu_en in RUN), CNT_W (step_cnt width).
// Build option: define STEP_CNT_EN to build the step counter; otherwise
// step_cnt is tied to zero.
module cpu_step_ctrl #(
  parameter int RUN_DIV = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             btn_mode,
  input  logic             cpu_halt,
  output logic             cpu_en,
  output logic             run_mode,
  output logic             halted,
  output logic [CNT_W-1:0] step_cnt
);

  import step_ctrl_pkg::*;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [DIV_W-1:0] div_r;
  logic             cpu_en_r;
  logic             cpu_en_nxt_s;
  logic             run_mode_r;
  logic             halted_r;
  logic             step_edge_s;
  logic             mode_edge_s;

  btn_edge_sync u_step_sync (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn_step),
    .edge_pulse (step_edge_s)
  );

  btn_edge_sync u_mode_sync (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn_mode),
    .edge_pulse (mode_edge_s)
  );

  // Next-state and next cpu_en; a halt request or a state change always
  // suppresses the enable pulse.
  always_comb begin
    state_nxt_s  = state_r;
    cpu_en_nxt_s = 1'b0;
    case (state_r)
      ST_STEP: begin
        if (cpu_halt) begin
          state_nxt_s = ST_HALT;
        end else if (mode_edge_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s  = ST_STEP;
          cpu_en_nxt_s = step_edge_s;
        end
      end
      ST_RUN: begin
        if (cpu_halt) begin
          state_nxt_s = ST_HALT;
        end else if (mode_edge_s) begin
          state_nxt_s = ST_STEP;
        end else begin
          state_nxt_s  = ST_RUN;
          cpu_en_nxt_s = (div_r == DIV_LAST);
        end
      end
      ST_HALT: begin
        if (mode_edge_s && !cpu_halt) begin
          state_nxt_s = ST_STEP;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_STEP;
      end
    endcase
  end

  // State register, registered decodes and cpu_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_STEP;
      cpu_en_r   <= 1'b0;
      run_mode_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cpu_en_r   <= cpu_en_nxt_s;
      run_mode_r <= (state_nxt_s == ST_RUN);
      halted_r   <= (state_nxt_s == ST_HALT);
    end
  end

  // RUN divider: held at zero outside RUN so it starts cleared on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= '0;
    end else if (state_r != ST_RUN) begin
      div_r <= '0;
    end else if (div_r == DIV_LAST) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  assign cpu_en   = cpu_en_r;
  assign run_mode = run_mode_r;
  assign halted   = halted_r;

`ifdef STEP_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Saturating count of issued cpu_en pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (cpu_en_r && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign step_cnt = cnt_r;
`else
  assign step_cnt = '0;
`endif

endmodule
